// File: rtl/cp0_regfile.sv
// CP0 register file fed by the WB-stage CP0 bus: BadVAddr, Count, Compare, Status, Cause, EPC.
// Optional timer (Count/Compare/TI) is built only when CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter int WB_TO_CP0_REGISTER_BUS_WD = 110
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
    input  logic [5:0]                           ext_int_in,
    output logic [31:0]                          cp0_rdata,
    output logic [31:0]                          cp0_epc,
    output logic [31:0]                          cp0_status,
    output logic [31:0]                          cp0_cause,
    output logic                                 cp0_int
);

    localparam logic [4:0] A_BADVADDR = 5'd8;
    localparam logic [4:0] A_COUNT    = 5'd9;
    localparam logic [4:0] A_COMPARE  = 5'd11;
    localparam logic [4:0] A_STATUS   = 5'd12;
    localparam logic [4:0] A_CAUSE    = 5'd13;
    localparam logic [4:0] A_EPC      = 5'd14;

    logic        w_ex;
    logic [4:0]  w_excode;
    logic [31:0] w_badvaddr;
    logic        w_bd;
    logic [31:0] w_pc;
    logic        w_mtc0_we;
    logic [4:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_eret;

    assign w_ex       = wb_to_cp0_register_bus[109];
    assign w_excode   = wb_to_cp0_register_bus[108:104];
    assign w_badvaddr = wb_to_cp0_register_bus[103:72];
    assign w_bd       = wb_to_cp0_register_bus[71];
    assign w_pc       = wb_to_cp0_register_bus[70:39];
    assign w_mtc0_we  = wb_to_cp0_register_bus[38];
    assign w_addr     = wb_to_cp0_register_bus[37:33];
    assign w_wdata    = wb_to_cp0_register_bus[32:1];
    assign w_eret     = wb_to_cp0_register_bus[0];

    // WB raises ex on ERET too, so a real exception is ex without eret
    logic w_exc;
    logic w_ret;
    logic w_mt;

    assign w_exc = w_ex & ~w_eret;
    assign w_ret = w_eret;
    assign w_mt  = w_mtc0_we & ~w_ex & ~w_eret;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im  <= 8'd0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_exc) begin
            r_exl <= 1'b1;
        end else if (w_ret) begin
            r_exl <= 1'b0;
        end else if (w_mt && w_addr == A_STATUS) begin
            r_im  <= w_wdata[15:8];
            r_exl <= w_wdata[1];
            r_ie  <= w_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bd      <= 1'b0;
            r_ip_hw   <= 6'd0;
            r_ip_sw   <= 2'd0;
            r_exccode <= 5'd0;
        end else begin
            r_ip_hw <= {ext_int_in[5] | w_ti, ext_int_in[4:0]};
            if (w_exc) begin
                r_exccode <= w_excode;
                if (!r_exl) begin
                    r_bd <= w_bd;
                end
            end else if (w_mt && w_addr == A_CAUSE) begin
                r_ip_sw <= w_wdata[9:8];
            end
        end
    end

    // Nested exceptions keep the original EPC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_epc <= 32'd0;
        end else if (w_exc) begin
            if (!r_exl) begin
                r_epc <= w_bd ? w_pc - 32'd4 : w_pc;
            end
        end else if (w_mt && w_addr == A_EPC) begin
            r_epc <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_badvaddr <= 32'd0;
        end else if (w_exc && (w_excode == 5'h04 || w_excode == 5'h05)) begin
            r_badvaddr <= w_badvaddr;
        end
    end

`ifdef CP0_TIMER_EN
    logic        r_tick;
    logic        r_ti;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick    <= 1'b0;
            r_ti      <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (w_mt && w_addr == A_COUNT) begin
                r_count <= w_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            // A Compare write acknowledges the timer even on a match cycle
            if (w_mt && w_addr == A_COMPARE) begin
                r_compare <= w_wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign w_ti      = r_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    logic [31:0] w_status;
    logic [31:0] w_cause;

    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'd0, r_ip_hw, r_ip_sw,
                       1'b0, r_exccode, 2'b00};

    always_comb begin
        cp0_rdata = 32'd0;
        case (w_addr)
            A_BADVADDR: cp0_rdata = r_badvaddr;
            A_COUNT:    cp0_rdata = w_count;
            A_COMPARE:  cp0_rdata = w_compare;
            A_STATUS:   cp0_rdata = w_status;
            A_CAUSE:    cp0_rdata = w_cause;
            A_EPC:      cp0_rdata = r_epc;
            default:    cp0_rdata = 32'd0;
        endcase
    end

    assign cp0_epc    = r_epc;
    assign cp0_status = w_status;
    assign cp0_cause  = w_cause;
    assign cp0_int    = (|(w_cause[15:8] & w_status[15:8])) & r_ie & ~r_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Random + directed bench for cp0_regfile against a word-level CP0 model.
// Timer checks follow CP0_TIMER_EN exactly like the design.
module tb_cp0_regfile;

    logic         clk;
    logic         reset;
    logic [109:0] bus;
    logic [5:0]   ext_int_in;
    logic [31:0]  cp0_rdata;
    logic [31:0]  cp0_epc;
    logic [31:0]  cp0_status;
    logic [31:0]  cp0_cause;
    logic         cp0_int;

    logic        t_ex;
    logic [4:0]  t_excode;
    logic [31:0] t_bva;
    logic        t_bd;
    logic [31:0] t_pc;
    logic        t_we;
    logic [4:0]  t_addr;
    logic [31:0] t_wdata;
    logic        t_eret;

    assign bus = {t_ex, t_excode, t_bva, t_bd, t_pc,
                  t_we, t_addr, t_wdata, t_eret};

    cp0_regfile dut (
        .clk                    (clk),
        .reset                  (reset),
        .wb_to_cp0_register_bus (bus),
        .ext_int_in             (ext_int_in),
        .cp0_rdata              (cp0_rdata),
        .cp0_epc                (cp0_epc),
        .cp0_status             (cp0_status),
        .cp0_cause              (cp0_cause),
        .cp0_int                (cp0_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_status;
    logic [31:0] m_cause;
    logic [31:0] m_epc;
    logic [31:0] m_bva;
    logic        m_ti;
`ifdef CP0_TIMER_EN
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_tick;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_cause  = 32'd0;
        m_epc    = 32'd0;
        m_bva    = 32'd0;
        m_ti     = 1'b0;
`ifdef CP0_TIMER_EN
        m_count   = 32'd0;
        m_compare = 32'd0;
        m_tick    = 1'b0;
`endif
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bva;
`ifdef CP0_TIMER_EN
            5'd9:  return m_count;
            5'd11: return m_compare;
`endif
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_int();
        return (|(m_cause[15:8] & m_status[15:8])) &
               m_status[0] & ~m_status[1];
    endfunction

    task automatic model_update();
        logic exc;
        logic ret;
        logic mt;
        logic ti_old;
        exc    = t_ex && !t_eret;
        ret    = t_eret;
        mt     = t_we && !t_ex && !t_eret;
        ti_old = m_ti;
        if (exc) begin
            if (!m_status[1]) begin
                m_epc      = t_bd ? t_pc - 32'd4 : t_pc;
                m_cause[31] = t_bd;
            end
            m_status[1]   = 1'b1;
            m_cause[6:2]  = t_excode;
            if (t_excode == 5'h04 || t_excode == 5'h05) m_bva = t_bva;
        end else if (ret) begin
            m_status[1] = 1'b0;
        end else if (mt) begin
            case (t_addr)
                5'd12: m_status = (t_wdata & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: m_cause = (m_cause & ~32'h300) | (t_wdata & 32'h300);
                5'd14: m_epc = t_wdata;
                default: ;
            endcase
        end
`ifdef CP0_TIMER_EN
        begin
            logic match;
            match = (m_count == m_compare);
            if (mt && t_addr == 5'd9) m_count = t_wdata;
            else m_count = m_count + {31'd0, m_tick};
            m_tick = ~m_tick;
            if (mt && t_addr == 5'd11) begin
                m_compare = t_wdata;
                m_ti = 1'b0;
            end else if (match) begin
                m_ti = 1'b1;
            end
        end
`endif
        m_cause[15:10] = {ext_int_in[5] | ti_old, ext_int_in[4:0]};
        m_cause[30]    = m_ti;
    endtask

    task automatic set_idle();
        t_ex = 0; t_excode = 0; t_bva = 0; t_bd = 0; t_pc = 0;
        t_we = 0; t_addr = 0; t_wdata = 0; t_eret = 0;
    endtask

    task automatic step();
        @(negedge clk);
        chk("rdata", cp0_rdata, m_read(t_addr));
        chk("epc", cp0_epc, m_epc);
        chk("status", cp0_status, m_status);
        chk("cause", cp0_cause, m_cause);
        chk("int", {31'd0, cp0_int}, {31'd0, m_int()});
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        set_idle();
        t_we = 1; t_addr = a; t_wdata = d;
        step();
        set_idle();
    endtask

    task automatic do_reset();
        logic [4:0] addrs [6];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
        t_ex = 1; t_excode = 5'h04; t_bva = $urandom; t_pc = $urandom;
        t_we = 1; t_addr = 5'd14; t_wdata = $urandom;
        reset = 1'b1;
        #1;
        chk("rst_status", cp0_status, 32'h0040_0000);
        chk("rst_cause", cp0_cause, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_int", {31'd0, cp0_int}, 32'd0);
        set_idle();
        foreach (addrs[i]) begin
            t_addr = addrs[i];
            #1;
            chk("rst_rd", cp0_rdata,
                (addrs[i] == 5'd12) ? 32'h0040_0000 : 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_idle();
    endtask

    initial begin
        logic [31:0] sv_cause;
        logic [4:0]  atab [7];
        reset = 1'b1;
        ext_int_in = 6'd0;
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        t_ex = 1; t_excode = 5'h04; t_bd = 1;
        t_pc = 32'hBFC0_0100; t_bva = 32'h0000_0003;
        step();
        set_idle();
        chk("exc_epc", cp0_epc, 32'hBFC0_00FC);
        chk("exc_cause", cp0_cause & 32'hBFFF_7FFF, 32'h8000_0010);
        chk("exc_exl", {31'd0, cp0_status[1]}, 32'd1);
        t_addr = 5'd8;
        #1;
        chk("exc_bva", cp0_rdata, 32'h0000_0003);

        t_ex = 1; t_excode = 5'h0A; t_pc = 32'h0000_0200;
        step();
        set_idle();
        chk("nest_epc", cp0_epc, 32'hBFC0_00FC);
        chk("nest_code", {27'd0, cp0_cause[6:2]}, 32'h0A);
        sv_cause = cp0_cause;

        t_ex = 1; t_eret = 1;
        step();
        set_idle();
        chk("eret_exl", {31'd0, cp0_status[1]}, 32'd0);
        chk("eret_epc", cp0_epc, 32'hBFC0_00FC);
        chk("eret_cause", cp0_cause & 32'hBFFF_7FFF,
            sv_cause & 32'hBFFF_7FFF);

        t_ex = 1; t_pc = 32'h0000_1000;
        t_we = 1; t_addr = 5'd14; t_wdata = 32'hDEAD_BEEF;
        step();
        set_idle();
        chk("drop_mtc0", cp0_epc, 32'h0000_1000);

        mtc0(5'd12, 32'h0000_0401);
        chk("st_wr", cp0_status, 32'h0040_0401);
        ext_int_in = 6'b000001;
        step();
        chk("int_on", {31'd0, cp0_int}, 32'd1);
        t_ex = 1; t_pc = 32'h0000_0300;
        step();
        set_idle();
        chk("int_exl", {31'd0, cp0_int}, 32'd0);
        ext_int_in = 6'd0;
        t_ex = 1; t_eret = 1;
        step();
        set_idle();

`ifdef CP0_TIMER_EN
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd5);
        chk("ti_clr", {31'd0, cp0_cause[30]}, 32'd0);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (cp0_int) break;
        end
        chk("timer_int", {31'd0, cp0_int}, 32'd1);
        chk("timer_ti", {31'd0, cp0_cause[30]}, 32'd1);
        mtc0(5'd11, 32'h100);
        mtc0(5'd9, 32'h100);
        mtc0(5'd11, 32'h100);
        chk("ti_cmp_wins", {31'd0, cp0_cause[30]}, 32'd0);
`else
        for (int i = 0; i < 100; i++) step();
        t_addr = 5'd9;
        #1;
        chk("cnt_off", cp0_rdata, 32'd0);
        mtc0(5'd9, 32'h1234);
        mtc0(5'd11, 32'h1);
        t_addr = 5'd9;
        #1;
        chk("cnt_wr_off", cp0_rdata, 32'd0);
        t_addr = 5'd11;
        #1;
        chk("cmp_wr_off", cp0_rdata, 32'd0);
`endif

        atab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        for (int n = 0; n < 1500; n++) begin
            int r;
            if (n % 400 == 399) do_reset();
            r = $urandom_range(0, 15);
            t_eret   = (r == 2 || r == 3);
            t_ex     = (r < 4);
            t_excode = ($urandom_range(0, 2) == 0) ?
                       5'(4 + $urandom_range(0, 1)) : 5'($urandom);
            t_bva    = $urandom;
            t_bd     = 1'($urandom);
            t_pc     = $urandom;
            t_we     = 1'($urandom);
            r        = $urandom_range(0, 6);
            t_addr   = (r == 6) ? 5'($urandom) : atab[r];
            t_wdata  = $urandom;
            if ($urandom_range(0, 7) == 0) ext_int_in = 6'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
